// File: rtl/divider.sv
// Iterative 32-cycle restoring divider for MIPS DIV/DIVU (LO = quotient, HI = remainder).
// Optional short path for |a| < |b| is enabled by defining DIV_EARLY_EXIT_EN.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_en,
  input  logic             div_signed,
  input  logic             div_cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             div_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_signed;
  logic             r_b_neg;
  logic             r_b_zero;
  logic [5:0]       r_cnt;

  logic             w_start;
  logic             w_early;
  logic             w_abort;
  logic             w_last;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_neg_q;
  logic             w_neg_r;
  logic [WIDTH-1:0] w_fin_q;
  logic [WIDTH-1:0] w_fin_r;

  assign w_abs_a = (div_signed && a[WIDTH-1]) ? -a : a;
  assign w_abs_b = (div_signed && b[WIDTH-1]) ? -b : b;

  assign w_start = (r_state == S_IDLE) && div_en && !div_cancel;
  assign w_abort = div_cancel || !div_en;
  assign w_last  = (r_state == S_RUN) && (r_cnt == LAST_STEP) && !w_abort;

`ifdef DIV_EARLY_EXIT_EN
  assign w_early = (b != '0) && (w_abs_a < w_abs_b);
`else
  assign w_early = 1'b0;
`endif

  // One restoring step: shift next dividend bit into the partial remainder, keep the
  // subtraction only when it does not borrow.
  assign w_shift    = {r_acc, r_q[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_divisor};
  assign w_ge       = !w_trial[WIDTH];
  assign w_acc_next = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_q_next   = {r_q[WIDTH-2:0], w_ge};

  assign w_neg_q = r_signed && (r_a[WIDTH-1] ^ r_b_neg);
  assign w_neg_r = r_signed && r_a[WIDTH-1];
  // Divide-by-zero bypasses sign fix-up so the remainder is the raw dividend.
  assign w_fin_q = r_b_zero ? '1  : (w_neg_q ? -w_q_next   : w_q_next);
  assign w_fin_r = r_b_zero ? r_a : (w_neg_r ? -w_acc_next : w_acc_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (div_cancel) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            w_next = w_early ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (!div_en) begin
            w_next = S_IDLE;
          end else if (r_cnt == LAST_STEP) begin
            w_next = S_DONE;
          end
        end
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    div_ready = (r_state == S_DONE);
    div_busy  = (r_state == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_divisor <= '0;
      r_q       <= '0;
      r_acc     <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_signed  <= 1'b0;
      r_b_neg   <= 1'b0;
      r_b_zero  <= 1'b0;
      r_cnt     <= '0;
    end else if (w_start) begin
      r_a       <= a;
      r_divisor <= w_abs_b;
      r_q       <= w_abs_a;
      r_acc     <= '0;
      r_signed  <= div_signed;
      r_b_neg   <= b[WIDTH-1];
      r_b_zero  <= (b == '0);
      r_cnt     <= '0;
      if (w_early) begin
        r_quot <= '0;
        r_rem  <= a;
      end
    end else if (r_state == S_RUN) begin
      r_acc <= w_acc_next;
      r_q   <= w_q_next;
      r_cnt <= r_cnt + 6'd1;
      if (w_last) begin
        r_quot <= w_fin_q;
        r_rem  <= w_fin_r;
      end
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_rem;

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; only 32 is supported for the MIPS DIV/DIVU path.
REQ-002 clk  input  1  Rising-edge clock for all state.
REQ-003 rst  input  1  Synchronous, active-high reset.
REQ-004 div_en  input  1  E-stage instruction is DIV/DIVU; held high by E-stage stall until div_ready is seen.
REQ-005 div_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled at start only.
REQ-006 div_cancel  input  1  Abort: E-stage flush, exception or ERET.
REQ-007 a  input  WIDTH  Dividend (rs); sampled at start only.
REQ-008 b  input  WIDTH  Divisor (rt); sampled at start only.
REQ-009 div_ready  output  1  Result valid; hazard computes divider_stall = div_en && !div_ready.
REQ-010 quotient  output  WIDTH  Quotient; written to LO.
REQ-011 remainder  output  WIDTH  Remainder; written to HI.
REQ-012 div_busy  output  1  High in RUN.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 IDLE: div_en=1 and div_cancel=0 SHALL latch a, b and div_signed, load |a| and |b| (magnitudes only when signed), clear the 6-bit iteration counter and go to RUN.
REQ-015 RUN SHALL perform one restoring shift-subtract step per cycle, MSB first, for exactly WIDTH cycles, then go to DONE.
REQ-016 Latency: div_en first high in IDLE in cycle T SHALL give div_ready=1 in cycle T+33 for WIDTH=32.
REQ-017 DONE SHALL assert div_ready for exactly one cycle, then go to IDLE unconditionally.
REQ-018 quotient/remainder SHALL be valid in the div_ready cycle and SHALL hold until the next start.
REQ-019 Signed sign rule: quotient negative iff sign(a)!=sign(b); remainder takes the sign of a; truncation toward zero.
REQ-020 Overflow case a=0x80000000, b=0xFFFFFFFF signed SHALL yield quotient 0x80000000, remainder 0.
REQ-021 b=0 (either mode) SHALL take the normal latency and yield quotient 0xFFFFFFFF, remainder = a unmodified.
REQ-022 Back-to-back: div_en still high in the cycle after DONE (new instruction in E) SHALL start a new operation from IDLE; no operation SHALL start from the DONE cycle.
REQ-023 div_cancel=1 in any state SHALL force IDLE at the next edge with div_ready=0; it takes priority over div_en.
REQ-024 div_en falling to 0 while in RUN SHALL abort to IDLE as for div_cancel.
REQ-025 Operand changes on a/b/div_signed during RUN SHALL NOT affect the result.

Reset
REQ-026 rst SHALL force state IDLE, counter 0, div_ready 0, div_busy 0, quotient 0 and remainder 0 at the next clk edge, overriding any in-flight operation.
REQ-027 With rst high, div_en SHALL be ignored.

Configuration
REQ-028 Macro DIV_EARLY_EXIT_EN SHALL enable the short path.
REQ-029 With DIV_EARLY_EXIT_EN defined, a start where |a|<|b| and b!=0 SHALL go IDLE->DONE directly: quotient 0, remainder a, div_ready in cycle T+1.
REQ-030 Without DIV_EARLY_EXIT_EN, every start SHALL take the full T+33 latency.

Verification
REQ-031 DIVU a=100, b=7, div_en held high -> div_ready in cycle T+33, quotient 14, remainder 2, one-cycle pulse.
REQ-032 DIV a=-7 (0xFFFFFFF9), b=2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); a=0x80000000, b=-1 -> quotient 0x80000000, remainder 0.
REQ-033 DIVU a=0x1234, b=0 -> quotient 0xFFFFFFFF, remainder 0x1234 at T+33.
REQ-034 Start DIVU, assert div_cancel in cycle T+10 -> IDLE next cycle, no div_ready; re-assert div_en -> clean result 33 cycles later.
REQ-035 Two DIVs back-to-back with div_en high continuously -> ready pulses at T+33 and T+67 with the correct second result.
REQ-036 DIV_EARLY_EXIT_EN defined: DIVU a=3, b=10 -> div_ready at T+1, quotient 0, remainder 3; undefined -> same values at T+33.
